// File: rtl/ao6_vector_sequencer.sv
// Self-test sequencer for one AO6 cell (Z = ~((A&B)|C)): sweeps all eight
// input vectors, samples Z after a settle interval and tallies mismatches.
module ao6_vector_sequencer #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned PASSES = 1
) (
    input  logic       CP,
    input  logic       CD,
    input  logic       START,
    input  logic       Z_IN,
    output logic       A_OUT,
    output logic       B_OUT,
    output logic       C_OUT,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [3:0] ERR_CNT,
    output logic [2:0] FAIL_VEC,
    output logic       FAIL_VALID
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        FINISH
    } state_t;

    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

    state_t     state;
    logic [2:0] vec;
    logic [3:0] settle_cnt;
    logic [3:0] pass_cnt;

    function automatic logic exp_z(input logic [2:0] v);
        return ~((v[2] & v[1]) | v[0]);
    endfunction

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            state      <= IDLE;
            A_OUT      <= 1'b0;
            B_OUT      <= 1'b0;
            C_OUT      <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            FAIL_VEC   <= '0;
            FAIL_VALID <= 1'b0;
            vec        <= '0;
            settle_cnt <= '0;
            pass_cnt   <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state      <= DRIVE;
                        BUSY       <= 1'b1;
                        PASS       <= 1'b0;
                        ERR_CNT    <= '0;
                        FAIL_VEC   <= '0;
                        FAIL_VALID <= 1'b0;
                        vec        <= '0;
                        pass_cnt   <= '0;
                    end
                end
                DRIVE: begin
                    {A_OUT, B_OUT, C_OUT} <= vec;
                    settle_cnt            <= '0;
                    state                 <= (SETTLE > 0) ? WAIT : SAMPLE;
                end
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    // Case-inequality so an undriven or unknown Z counts as a miss
                    if (Z_IN !== exp_z(vec)) begin
                        if (ERR_CNT != 4'hF) begin
                            ERR_CNT <= ERR_CNT + 4'd1;
                        end
                        if (!FAIL_VALID) begin
                            FAIL_VEC   <= vec;
                            FAIL_VALID <= 1'b1;
                        end
                    end
                    if (vec != 3'd7) begin
                        vec   <= vec + 3'd1;
                        state <= DRIVE;
                    end else if (pass_cnt != PASS_LAST) begin
                        vec      <= '0;
                        pass_cnt <= pass_cnt + 4'd1;
                        state    <= DRIVE;
                    end else begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    DONE                  <= 1'b1;
                    PASS                  <= (ERR_CNT == 4'd0);
                    BUSY                  <= 1'b0;
                    {A_OUT, B_OUT, C_OUT} <= 3'b000;
                    state                 <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ao6_vector_sequencer.sv
// Directed bench for ao6_vector_sequencer: three instances (defaults, PASSES=3,
// SETTLE=0) driven by a selectable AO6 / faulty-cell model.
module tb_ao6_vector_sequencer;

    logic CP = 1'b0;
    logic CD = 1'b0;

    logic       start_v  [3];
    logic       z_v      [3];
    logic       a_v      [3];
    logic       b_v      [3];
    logic       c_v      [3];
    logic       busy_v   [3];
    logic       done_v   [3];
    logic       pass_v   [3];
    logic [3:0] err_v    [3];
    logic [2:0] fvec_v   [3];
    logic       fvalid_v [3];

    int unsigned zmode;
    int          checks = 0;
    int          errors = 0;
    int          de;

    always #5 CP = ~CP;

    // 0 good AO6, 1 stuck-at-0, 2 stuck-at-1, 3 NAND3, 4 AO6 with wrong Z on 101
    function automatic logic zmodel(input int unsigned mode, input logic [2:0] v);
        case (mode)
            0:       return ~((v[2] & v[1]) | v[0]);
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~(&v);
            4:       return (v == 3'b101) ? 1'b1 : ~((v[2] & v[1]) | v[0]);
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            z_v[i] = zmodel(zmode, {a_v[i], b_v[i], c_v[i]});
        end
    end

    ao6_vector_sequencer u_def (
        .CP(CP), .CD(CD), .START(start_v[0]), .Z_IN(z_v[0]),
        .A_OUT(a_v[0]), .B_OUT(b_v[0]), .C_OUT(c_v[0]),
        .BUSY(busy_v[0]), .DONE(done_v[0]), .PASS(pass_v[0]),
        .ERR_CNT(err_v[0]), .FAIL_VEC(fvec_v[0]), .FAIL_VALID(fvalid_v[0])
    );

    ao6_vector_sequencer #(.SETTLE(2), .PASSES(3)) u_p3 (
        .CP(CP), .CD(CD), .START(start_v[1]), .Z_IN(z_v[1]),
        .A_OUT(a_v[1]), .B_OUT(b_v[1]), .C_OUT(c_v[1]),
        .BUSY(busy_v[1]), .DONE(done_v[1]), .PASS(pass_v[1]),
        .ERR_CNT(err_v[1]), .FAIL_VEC(fvec_v[1]), .FAIL_VALID(fvalid_v[1])
    );

    ao6_vector_sequencer #(.SETTLE(0), .PASSES(1)) u_s0 (
        .CP(CP), .CD(CD), .START(start_v[2]), .Z_IN(z_v[2]),
        .A_OUT(a_v[2]), .B_OUT(b_v[2]), .C_OUT(c_v[2]),
        .BUSY(busy_v[2]), .DONE(done_v[2]), .PASS(pass_v[2]),
        .ERR_CNT(err_v[2]), .FAIL_VEC(fvec_v[2]), .FAIL_VALID(fvalid_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_zero(input int d, input string tag);
        check({tag, "_abc"},    32'({a_v[d], b_v[d], c_v[d]}), 32'd0);
        check({tag, "_busy"},   32'(busy_v[d]),   32'd0);
        check({tag, "_done"},   32'(done_v[d]),   32'd0);
        check({tag, "_pass"},   32'(pass_v[d]),   32'd0);
        check({tag, "_err"},    32'(err_v[d]),    32'd0);
        check({tag, "_fvec"},   32'(fvec_v[d]),   32'd0);
        check({tag, "_fvalid"}, 32'(fvalid_v[d]), 32'd0);
    endtask

    // Edge 0 is the edge that samples START; done_edge is the edge after which DONE reads high.
    task automatic run(input int d, input int restart_edge, input bit trace, output int done_edge);
        @(negedge CP);
        start_v[d] = 1'b1;
        @(posedge CP);
        #1;
        start_v[d] = 1'b0;
        check("accept_busy",   32'(busy_v[d]),   32'd1);
        check("accept_err",    32'(err_v[d]),    32'd0);
        check("accept_pass",   32'(pass_v[d]),   32'd0);
        check("accept_fvalid", 32'(fvalid_v[d]), 32'd0);
        done_edge = -1;
        for (int e = 1; e <= 200; e++) begin
            if (e == restart_edge) start_v[d] = 1'b1;
            @(posedge CP);
            #1;
            start_v[d] = 1'b0;
            if (trace && e <= 32) begin
                check("abc_seq", 32'({a_v[d], b_v[d], c_v[d]}), 32'((e - 1) / 4));
                check("busy_run", 32'(busy_v[d]), 32'd1);
            end
            if (done_v[d]) begin
                done_edge = e;
                break;
            end
        end
        check("done_abc_zero", 32'({a_v[d], b_v[d], c_v[d]}), 32'd0);
        check("done_busy_low", 32'(busy_v[d]), 32'd0);
        @(posedge CP);
        #1;
        check("done_one_cycle", 32'(done_v[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        zmode = 0;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

        repeat (3) @(posedge CP);
        #1;
        for (int i = 0; i < 3; i++) check_idle_zero(i, "reset");
        @(negedge CP);
        CD = 1'b1;

        zmode = 0;
        run(0, 0, 1'b1, de);
        check("good_done_edge", 32'(de), 32'd33);
        check("good_pass",   32'(pass_v[0]),   32'd1);
        check("good_err",    32'(err_v[0]),    32'd0);
        check("good_fvalid", 32'(fvalid_v[0]), 32'd0);

        zmode = 1;
        run(0, 0, 1'b0, de);
        check("sa0_done_edge", 32'(de), 32'd33);
        check("sa0_err",    32'(err_v[0]),    32'd3);
        check("sa0_fvec",   32'(fvec_v[0]),   32'd0);
        check("sa0_fvalid", 32'(fvalid_v[0]), 32'd1);
        check("sa0_pass",   32'(pass_v[0]),   32'd0);

        zmode = 2;
        run(1, 0, 1'b0, de);
        check("sa1_done_edge", 32'(de), 32'd97);
        check("sa1_err",    32'(err_v[1]),    32'd15);
        check("sa1_fvec",   32'(fvec_v[1]),   32'd1);
        check("sa1_fvalid", 32'(fvalid_v[1]), 32'd1);
        check("sa1_pass",   32'(pass_v[1]),   32'd0);

        zmode = 0;
        run(2, 0, 1'b0, de);
        check("s0_done_edge", 32'(de), 32'd17);
        check("s0_pass", 32'(pass_v[2]), 32'd1);
        check("s0_err",  32'(err_v[2]),  32'd0);

        // NAND3 differs from AO6 on 001, 011, 101 and 110
        zmode = 3;
        run(2, 0, 1'b0, de);
        check("nand_done_edge", 32'(de), 32'd17);
        check("nand_err",    32'(err_v[2]),    32'd4);
        check("nand_fvec",   32'(fvec_v[2]),   32'd1);
        check("nand_fvalid", 32'(fvalid_v[2]), 32'd1);
        check("nand_pass",   32'(pass_v[2]),   32'd0);

        zmode = 0;
        run(0, 10, 1'b1, de);
        check("restart_done_edge", 32'(de), 32'd33);
        check("restart_pass", 32'(pass_v[0]), 32'd1);

        zmode = 4;
        run(0, 0, 1'b0, de);
        check("bad101_done_edge", 32'(de), 32'd33);
        check("bad101_err",    32'(err_v[0]),    32'd1);
        check("bad101_fvec",   32'(fvec_v[0]),   32'd5);
        check("bad101_fvalid", 32'(fvalid_v[0]), 32'd1);
        check("bad101_pass",   32'(pass_v[0]),   32'd0);

        zmode = 0;
        run(0, 0, 1'b0, de);
        check("rerun_done_edge", 32'(de), 32'd33);
        check("rerun_pass", 32'(pass_v[0]), 32'd1);

        @(negedge CP);
        start_v[0] = 1'b1;
        @(posedge CP);
        #1;
        start_v[0] = 1'b0;
        repeat (20) @(posedge CP);
        #1;
        check("abort_pre_abc", 32'({a_v[0], b_v[0], c_v[0]}), 32'd4);
        CD = 1'b0;
        #1;
        check_idle_zero(0, "abort");
        @(negedge CP);
        CD = 1'b1;
        seen = 1'b0;
        for (int e = 0; e < 50; e++) begin
            @(posedge CP);
            #1;
            if (done_v[0] || busy_v[0]) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        run(0, 0, 1'b0, de);
        check("post_abort_done_edge", 32'(de), 32'd33);
        check("post_abort_pass", 32'(pass_v[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
